pix_capture: RTL and testbench

PIX_CAPTURE -- requirements
Module: pix_capture

---
 rtl/pix_capture.sv | 244 ++++++++++++++++++++++++
 tb/tb_pix_capture.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pix_capture.sv
// pix_capture
//    Captures frames from a parallel 12-bit camera sensor and packs pixels
//    two per 32-bit word into a small output FIFO with a ready/valid port.
//
//    Ports
//       pixclk        pixel clock, all logic on the rising edge
//       reset_b       asynchronous active-low reset
//       capture_en    arms capture; only looked at when a frame starts
//       frame_valid   sensor frame valid
//       line_valid    sensor line valid
//       din           sensor pixel (12 bits)
//       out_data      packed word, pixel N in [15:0], pixel N+1 in [31:16]
//       out_valid     FIFO not empty
//       out_ready     downstream accepts the head word
//       out_sof       head word is the first word of a frame
//       out_eof       head word is the last word of a frame
//       frame_done    one-cycle pulse when a captured frame has been closed
//       overflow      sticky: a word was dropped because the FIFO was full
//       frame_width   pixels in the last line of the last captured frame
//       frame_height  lines in the last captured frame
//
//    Build option
//       FRAME_STATS_EN  when defined, builds the width/height counters;
//                       otherwise frame_width/frame_height are tied to 0.

module pix_capture #(
   parameter int WORD_FIFO_DEPTH = 2,
   parameter int CNT_W           = 12
) (
   input  logic             pixclk,
   input  logic             reset_b,
   input  logic             capture_en,
   input  logic             frame_valid,
   input  logic             line_valid,
   input  logic [11:0]      din,
   output logic [31:0]      out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sof,
   output logic             out_eof,
   output logic             frame_done,
   output logic             overflow,
   output logic [CNT_W-1:0] frame_width,
   output logic [CNT_W-1:0] frame_height
);

   localparam int AW = $clog2(WORD_FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(WORD_FIFO_DEPTH);

   typedef enum logic [1:0] {
      WAIT_LOW,
      ARMED,
      ACTIVE,
      FLUSH
   } state_t;

   state_t      state;
   logic        fv_q, fv_q1, lv_q;
   logic [11:0] din_q;

   logic        half_valid;
   logic [11:0] half_data;
   logic        pend_valid;
   logic [31:0] pend_data;
   logic        first_word;

   logic        wr_req, wr_sof, wr_eof;
   logic [31:0] wr_data;

   logic [33:0] mem [WORD_FIFO_DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count;

   logic start, sample, pop, full, push, drop;

   // Sensor inputs are registered once. frame_valid and its delayed copy
   // reset high so that a reset released in the middle of a frame cannot
   // look like a fresh rising edge: the FSM must first see it low.
   always_ff @(posedge pixclk or negedge reset_b) begin
      if (!reset_b) begin
         fv_q  <= 1'b1;
         fv_q1 <= 1'b1;
         lv_q  <= 1'b0;
         din_q <= '0;
      end else begin
         fv_q  <= frame_valid;
         fv_q1 <= fv_q;
         lv_q  <= line_valid;
         din_q <= din;
      end
   end

   assign start  = (state == ARMED) && fv_q && !fv_q1 && capture_en;
   assign sample = (state == ACTIVE) && fv_q && lv_q;

   // Capture FSM and pixel packer. A finished pair sits in the pending
   // register until the next pixel proves it is not the last word of the
   // frame; only then is it issued as a non-eof write. On frame end the
   // open half-word (padded) or the pending word is issued with eof set.
   // Writes are issued through a one-cycle request register into the FIFO.
   always_ff @(posedge pixclk or negedge reset_b) begin
      if (!reset_b) begin
         state      <= WAIT_LOW;
         half_valid <= 1'b0;
         half_data  <= '0;
         pend_valid <= 1'b0;
         pend_data  <= '0;
         first_word <= 1'b0;
         wr_req     <= 1'b0;
         wr_data    <= '0;
         wr_sof     <= 1'b0;
         wr_eof     <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         wr_req     <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            WAIT_LOW: begin
               if (!fv_q) state <= ARMED;
            end
            ARMED: begin
               if (start) begin
                  state      <= ACTIVE;
                  first_word <= 1'b1;
                  half_valid <= 1'b0;
                  pend_valid <= 1'b0;
               end
            end
            ACTIVE: begin
               if (!fv_q) begin
                  state <= FLUSH;
               end else if (sample) begin
                  if (half_valid) begin
                     pend_data  <= {4'h0, din_q, 4'h0, half_data};
                     pend_valid <= 1'b1;
                     half_valid <= 1'b0;
                  end else begin
                     half_data  <= din_q;
                     half_valid <= 1'b1;
                     if (pend_valid) begin
                        wr_req     <= 1'b1;
                        wr_data    <= pend_data;
                        wr_sof     <= first_word;
                        wr_eof     <= 1'b0;
                        first_word <= 1'b0;
                        pend_valid <= 1'b0;
                     end
                  end
               end
            end
            FLUSH: begin
               if (half_valid) begin
                  wr_req  <= 1'b1;
                  wr_data <= {20'h0, half_data};
                  wr_sof  <= first_word;
                  wr_eof  <= 1'b1;
               end else if (pend_valid) begin
                  wr_req  <= 1'b1;
                  wr_data <= pend_data;
                  wr_sof  <= first_word;
                  wr_eof  <= 1'b1;
               end
               half_valid <= 1'b0;
               pend_valid <= 1'b0;
               first_word <= 1'b0;
               frame_done <= 1'b1;
               state      <= ARMED;
            end
            default: state <= WAIT_LOW;
         endcase
      end
   end

   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;
   assign full      = (count == DEPTH_C);
   assign push      = wr_req && (!full || pop);
   assign drop      = wr_req && full && !pop;

   // FIFO storage; contents are don't-care while empty because the
   // outputs are masked by out_valid.
   always_ff @(posedge pixclk) begin
      if (push) mem[wr_ptr] <= {wr_sof, wr_eof, wr_data};
   end

   // FIFO pointers and occupancy, plus the sticky overflow flag. A write
   // into a full FIFO that is being read in the same cycle still fits.
   always_ff @(posedge pixclk or negedge reset_b) begin
      if (!reset_b) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         if (drop)       overflow <= 1'b1;
         else if (start) overflow <= 1'b0;
      end
   end

   assign out_data = out_valid ? mem[rd_ptr][31:0] : 32'h0;
   assign out_eof  = out_valid ? mem[rd_ptr][32]   : 1'b0;
   assign out_sof  = out_valid ? mem[rd_ptr][33]   : 1'b0;

`ifdef FRAME_STATS_EN
   logic             lv_q1;
   logic [CNT_W-1:0] width_cnt, height_cnt;

   // Line and pixel counters for the frame in progress. The pixel count
   // restarts on each line, so at frame end it holds the last line length.
   // Results are published when the frame is closed.
   always_ff @(posedge pixclk or negedge reset_b) begin
      if (!reset_b) begin
         lv_q1        <= 1'b0;
         width_cnt    <= '0;
         height_cnt   <= '0;
         frame_width  <= '0;
         frame_height <= '0;
      end else begin
         lv_q1 <= lv_q;
         if (start) begin
            width_cnt  <= '0;
            height_cnt <= '0;
         end else begin
            if ((state == ACTIVE) && fv_q && lv_q && !lv_q1)
               height_cnt <= height_cnt + 1'b1;
            if (sample)
               width_cnt <= lv_q1 ? width_cnt + 1'b1 : CNT_W'(1);
         end
         if (state == FLUSH) begin
            frame_width  <= width_cnt;
            frame_height <= height_cnt;
         end
      end
   end
`else
   assign frame_width  = '0;
   assign frame_height = '0;
`endif

endmodule

// File: tb/tb_pix_capture.sv
// tb_pix_capture
//    Directed bench for pix_capture: normal frames, an odd-length frame,
//    latency, backpressure overflow, disarmed capture, mid-line reset and
//    an empty frame. A monitor logs every transferred word into queues.

module tb_pix_capture;

   logic        pixclk = 1'b0;
   logic        reset_b;
   logic        capture_en;
   logic        frame_valid;
   logic        line_valid;
   logic [11:0] din;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_sof;
   logic        out_eof;
   logic        frame_done;
   logic        overflow;
   logic [11:0] frame_width;
   logic [11:0] frame_height;

   int compared   = 0;
   int mismatched = 0;
   int doneCount  = 0;

   logic [31:0] qData[$];
   logic        qSof[$];
   logic        qEof[$];

`ifdef FRAME_STATS_EN
   localparam logic [31:0] EXP_W = 32'd14;
   localparam logic [31:0] EXP_H = 32'd12;
`else
   localparam logic [31:0] EXP_W = 32'd0;
   localparam logic [31:0] EXP_H = 32'd0;
`endif

   pix_capture dut (
      .pixclk       (pixclk),
      .reset_b      (reset_b),
      .capture_en   (capture_en),
      .frame_valid  (frame_valid),
      .line_valid   (line_valid),
      .din          (din),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_sof      (out_sof),
      .out_eof      (out_eof),
      .frame_done   (frame_done),
      .overflow     (overflow),
      .frame_width  (frame_width),
      .frame_height (frame_height)
   );

   always #5 pixclk = ~pixclk;

   // Inputs change 2 time units after the rising edge, so the falling edge
   // sees stable handshake values for the upcoming rising edge.
   always @(negedge pixclk) begin
      if (reset_b) begin
         if (out_valid && out_ready) begin
            qData.push_back(out_data);
            qSof.push_back(out_sof);
            qEof.push_back(out_eof);
         end
         if (frame_done) doneCount++;
      end
   end

   task automatic tick;
      @(posedge pixclk);
      #2;
   endtask

   task automatic clearLog;
      qData.delete();
      qSof.delete();
      qEof.delete();
      doneCount = 0;
   endtask

   function automatic logic [31:0] wordAt(input int i);
      if (i < qData.size()) return qData[i];
      return 'x;
   endfunction

   function automatic logic sofAt(input int i);
      if (i < qSof.size()) return qSof[i];
      return 1'bx;
   endfunction

   function automatic logic eofAt(input int i);
      if (i < qEof.size()) return qEof[i];
      return 1'bx;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One frame of w x h pixels, value = row*w + col. If toggleEn is set,
   // capture_en is inverted after the first line.
   task automatic applyStimulus(input int w, input int h, input bit toggleEn);
      frame_valid = 1'b1;
      repeat (3) tick();
      for (int r = 0; r < h; r++) begin
         line_valid = 1'b1;
         for (int c = 0; c < w; c++) begin
            din = 12'(r * w + c);
            tick();
         end
         line_valid = 1'b0;
         din        = '0;
         if (r == 0 && toggleEn) capture_en = ~capture_en;
         repeat (2) tick();
      end
      frame_valid = 1'b0;
      repeat (8) tick();
   endtask

   initial begin
      reset_b     = 1'b0;
      capture_en  = 1'b1;
      frame_valid = 1'b0;
      line_valid  = 1'b0;
      din         = '0;
      out_ready   = 1'b1;
      repeat (3) tick();

      checkOutput("rst_valid",  32'(out_valid),    32'd0);
      checkOutput("rst_data",   out_data,          32'd0);
      checkOutput("rst_sof",    32'(out_sof),      32'd0);
      checkOutput("rst_eof",    32'(out_eof),      32'd0);
      checkOutput("rst_done",   32'(frame_done),   32'd0);
      checkOutput("rst_ovf",    32'(overflow),     32'd0);
      checkOutput("rst_width",  32'(frame_width),  32'd0);
      checkOutput("rst_height", 32'(frame_height), 32'd0);

      reset_b = 1'b1;
      repeat (5) tick();

      // 3x1 frame, checking latency of the first word on the way
      clearLog();
      frame_valid = 1'b1;
      repeat (3) tick();
      line_valid = 1'b1;
      din = 12'd0; tick();
      din = 12'd1; tick();
      din = 12'd2; tick();
      line_valid = 1'b0;
      din        = '0;
      checkOutput("lat_e0", 32'(out_valid), 32'd0);
      tick();
      checkOutput("lat_e1", 32'(out_valid), 32'd0);
      tick();
      checkOutput("lat_e2", 32'(out_valid), 32'd1);
      repeat (2) tick();
      frame_valid = 1'b0;
      repeat (8) tick();
      checkOutput("f3_count", 32'(qData.size()), 32'd2);
      checkOutput("f3_w0",    wordAt(0),         32'h0001_0000);
      checkOutput("f3_sof0",  32'(sofAt(0)),     32'd1);
      checkOutput("f3_eof0",  32'(eofAt(0)),     32'd0);
      checkOutput("f3_w1",    wordAt(1),         32'h0000_0002);
      checkOutput("f3_eof1",  32'(eofAt(1)),     32'd1);
      checkOutput("f3_done",  32'(doneCount),    32'd1);

      // 14x12 frame with free-flowing output
      clearLog();
      applyStimulus(14, 12, 1'b0);
      checkOutput("f14_count",  32'(qData.size()), 32'd84);
      checkOutput("f14_w0",     wordAt(0),         32'h0001_0000);
      checkOutput("f14_sof0",   32'(sofAt(0)),     32'd1);
      checkOutput("f14_sof1",   32'(sofAt(1)),     32'd0);
      checkOutput("f14_w7",     wordAt(7),         32'h000F_000E);
      checkOutput("f14_eof82",  32'(eofAt(82)),    32'd0);
      checkOutput("f14_last",   wordAt(83),        32'h00A7_00A6);
      checkOutput("f14_eof83",  32'(eofAt(83)),    32'd1);
      checkOutput("f14_done",   32'(doneCount),    32'd1);
      checkOutput("f14_width",  32'(frame_width),  EXP_W);
      checkOutput("f14_height", 32'(frame_height), EXP_H);
      checkOutput("f14_ovf",    32'(overflow),     32'd0);

      // 14x12 frame with the output stalled throughout
      clearLog();
      out_ready = 1'b0;
      applyStimulus(14, 12, 1'b0);
      checkOutput("ovf_flag",  32'(overflow),     32'd1);
      checkOutput("ovf_valid", 32'(out_valid),    32'd1);
      checkOutput("ovf_head",  out_data,          32'h0001_0000);
      checkOutput("ovf_hsof",  32'(out_sof),      32'd1);
      out_ready = 1'b1;
      repeat (4) tick();
      checkOutput("ovf_count", 32'(qData.size()), 32'd2);
      checkOutput("ovf_w0",    wordAt(0),         32'h0001_0000);
      checkOutput("ovf_sof0",  32'(sofAt(0)),     32'd1);
      checkOutput("ovf_w1",    wordAt(1),         32'h0003_0002);
      checkOutput("ovf_empty", 32'(out_valid),    32'd0);
      checkOutput("ovf_stick", 32'(overflow),     32'd1);

      // empty frame: clears overflow at start, no words, still frame_done
      clearLog();
      frame_valid = 1'b1;
      repeat (3) tick();
      checkOutput("ovf_clear", 32'(overflow), 32'd0);
      frame_valid = 1'b0;
      repeat (8) tick();
      checkOutput("empty_words", 32'(qData.size()), 32'd0);
      checkOutput("empty_done",  32'(doneCount),    32'd1);

      // disarmed at frame start, enabled mid-frame, then a real frame
      clearLog();
      capture_en = 1'b0;
      applyStimulus(4, 2, 1'b1);
      checkOutput("dis_words", 32'(qData.size()), 32'd0);
      checkOutput("dis_done",  32'(doneCount),    32'd0);
      applyStimulus(4, 2, 1'b0);
      checkOutput("arm_count", 32'(qData.size()), 32'd4);
      checkOutput("arm_w0",    wordAt(0),         32'h0001_0000);
      checkOutput("arm_sof0",  32'(sofAt(0)),     32'd1);
      checkOutput("arm_w3",    wordAt(3),         32'h0007_0006);
      checkOutput("arm_eof3",  32'(eofAt(3)),     32'd1);
      checkOutput("arm_done",  32'(doneCount),    32'd1);

      // reset pulsed in the middle of a line
      frame_valid = 1'b1;
      repeat (3) tick();
      line_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         din = 12'(c);
         tick();
      end
      reset_b = 1'b0;
      #1;
      clearLog();
      checkOutput("mrst_valid", 32'(out_valid),  32'd0);
      checkOutput("mrst_data",  out_data,        32'd0);
      checkOutput("mrst_sof",   32'(out_sof),    32'd0);
      checkOutput("mrst_eof",   32'(out_eof),    32'd0);
      checkOutput("mrst_done",  32'(frame_done), 32'd0);
      checkOutput("mrst_ovf",   32'(overflow),   32'd0);
      tick();
      reset_b = 1'b1;
      for (int c = 6; c < 12; c++) begin
         din = 12'(c);
         tick();
      end
      line_valid = 1'b0;
      repeat (2) tick();
      line_valid = 1'b1;
      repeat (6) tick();
      line_valid  = 1'b0;
      frame_valid = 1'b0;
      repeat (8) tick();
      checkOutput("mrst_ignored", 32'(qData.size()), 32'd0);
      checkOutput("mrst_nodone",  32'(doneCount),    32'd0);
      applyStimulus(3, 1, 1'b0);
      checkOutput("post_count", 32'(qData.size()), 32'd2);
      checkOutput("post_w0",    wordAt(0),         32'h0001_0000);
      checkOutput("post_w1",    wordAt(1),         32'h0000_0002);
      checkOutput("post_eof1",  32'(eofAt(1)),     32'd1);
      checkOutput("post_done",  32'(doneCount),    32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
